// File: rtl/fifo_bank_ctrl_if.sv
// Host/controller handshake bundle for the FIFO-bank sequencer.
// master = host side (issues writes and start), slave = fifo_bank_ctrl.
// LW must match the lane-index width derived inside fifo_bank_ctrl.
interface fifo_bank_ctrl_if #(
  parameter int LANES = 4
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic             wr_valid;
  logic [LW-1:0]    wr_lane;
  logic             wr_ready;
  logic             wr_err;
  logic             start;
  logic             busy;
  logic             done;
  logic [LANES-1:0] fifo_en;
  logic             fifo_din_zero;
  logic [LANES-1:0] out_valid;

  modport master (
    output wr_valid, wr_lane, start,
    input  wr_ready, wr_err, busy, done, fifo_en, fifo_din_zero, out_valid
  );

  modport slave (
    input  wr_valid, wr_lane, start,
    output wr_ready, wr_err, busy, done, fifo_en, fifo_din_zero, out_valid
  );
endinterface

// File: rtl/fifo_bank_ctrl.sv
// Sequencer for a bank of shift-register delay FIFOs.
// IDLE: host writes are steered into one lane at a time and counted.
// STREAM: lanes drain with a one-cycle-per-lane skew while zeros shift in;
// out_valid marks which emitted words are loaded data rather than padding.
module fifo_bank_ctrl #(
  parameter int LANES = 4,
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  fifo_bank_ctrl_if.slave bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(LANES + DEPTH);
  // Last stream step: lane LANES-1 finishes its DEPTH shifts here.
  localparam logic [TW-1:0] T_LAST = TW'(LANES + DEPTH - 2);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [TW-1:0]    t_r;
  logic [TW-1:0]    t_nxt_s;
  logic [CW-1:0]    cnt_r [LANES];
  logic [LANES-1:0] lane_hit_s;
  logic [LANES-1:0] lane_room_s;
  logic             wr_ready_s;
  logic             wr_err_r;
  logic             done_r;
  logic             last_step_s;
  logic             din_zero_s;
  logic [LANES-1:0] fifo_en_s;
  logic [LANES-1:0] out_valid_s;

  // Decode the write lane; an out-of-range index hits no lane and is rejected.
  always_comb begin
    lane_hit_s  = '0;
    lane_room_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_hit_s[i]  = (bus.wr_lane == LW'(i));
      lane_room_s[i] = lane_hit_s[i] && (cnt_r[i] < CW'(DEPTH));
    end
    wr_ready_s = (state_r == ST_IDLE) && bus.wr_valid && (|lane_room_s);
  end

  // Next-state logic and per-lane enables / valids.
  always_comb begin
    state_nxt_s = state_r;
    t_nxt_s     = t_r;
    fifo_en_s   = '0;
    out_valid_s = '0;
    din_zero_s  = 1'b0;
    last_step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        fifo_en_s = wr_ready_s ? lane_hit_s : '0;
        if (bus.start) begin
          state_nxt_s = ST_STREAM;
          t_nxt_s     = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        din_zero_s = 1'b1;
        // Lane i is at step t-i; a lane holding cnt words emits
        // DEPTH-cnt padding words before its first real word.
        for (int i = 0; i < LANES; i++) begin
          fifo_en_s[i]   = (int'(t_r) >= i) && (int'(t_r) < i + DEPTH);
          out_valid_s[i] = fifo_en_s[i] &&
                           ((int'(t_r) - i) >= (DEPTH - int'(cnt_r[i])));
        end
        if (t_r == T_LAST) begin
          last_step_s = 1'b1;
          state_nxt_s = ST_IDLE;
          t_nxt_s     = '0;
        end else begin
          t_nxt_s     = t_r + TW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        t_nxt_s     = '0;
      end
    endcase
  end

  // State register and stream step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      t_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      t_r     <= t_nxt_s;
    end
  end

  // Per-lane fill counts; the end of a stream leaves every FIFO empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) cnt_r[i] <= '0;
    end else if (last_step_s) begin
      for (int i = 0; i < LANES; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_ready_s && lane_hit_s[i]) cnt_r[i] <= cnt_r[i] + CW'(1);
      end
    end
  end

  // One-cycle status pulses: rejected write and stream completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      wr_err_r <= bus.wr_valid && !wr_ready_s;
      done_r   <= last_step_s;
    end
  end

  assign bus.wr_ready      = wr_ready_s;
  assign bus.wr_err        = wr_err_r;
  assign bus.busy          = (state_r == ST_STREAM);
  assign bus.done          = done_r;
  assign bus.fifo_en       = fifo_en_s;
  assign bus.fifo_din_zero = din_zero_s;
  assign bus.out_valid     = out_valid_s;
endmodule

// File: tb/tb_fifo_bank_ctrl.sv
// Bench for fifo_bank_ctrl: a behavioural FIFO bank follows the controller's
// enables; loaded words are queued when written and popped when emitted.
module tb_fifo_bank_ctrl;
  localparam int LANES = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_bank_ctrl_if #(.LANES(LANES)) bus ();
  fifo_bank_ctrl_if #(.LANES(3))     bus3 ();

  fifo_bank_ctrl #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  fifo_bank_ctrl #(.LANES(3), .DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
  );

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] data;
  } sb_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_cnt [LANES];
  sb_t        sb_q [$];
  logic [7:0] host_d;
  logic [7:0] mem [LANES][DEPTH];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural FIFO bank: index 0 newest, DEPTH-1 oldest (q).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++)
        for (int k = 0; k < DEPTH; k++) mem[i][k] <= 8'h00;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.fifo_en[i]) begin
          mem[i][0] <= bus.fifo_din_zero ? 8'h00 : host_d;
          for (int k = 1; k < DEPTH; k++) mem[i][k] <= mem[i][k-1];
        end
      end
    end
  end

  // Scoreboard: every flagged word must be the oldest outstanding write to that lane.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.fifo_en[i] && bus.out_valid[i]) begin
          automatic int found = -1;
          for (int j = 0; j < sb_q.size(); j++) begin
            if (found < 0 && int'(sb_q[j].lane) == i) found = j;
          end
          if (found < 0) begin
            check_val($sformatf("sb_unexpected_lane%0d", i), 32'd1, 32'd0);
          end else begin
            check_val($sformatf("q_lane%0d", i), 32'(mem[i][DEPTH-1]), 32'(sb_q[found].data));
            sb_q.delete(found);
          end
        end
      end
    end
  end

  task automatic push_exp(input int lane, input logic [7:0] data);
    sb_t e;
    e.lane = 2'(lane);
    e.data = data;
    sb_q.push_back(e);
    exp_cnt[lane]++;
  endtask

  // Caller is just after a rising edge; returns just after a rising edge.
  task automatic do_write(input int lane, input logic [7:0] data, input bit ok);
    bus.wr_valid = 1'b1;
    bus.wr_lane  = 2'(lane);
    host_d       = data;
    @(negedge clk);
    check_val("wr_ready", 32'(bus.wr_ready), 32'(ok));
    check_val("wr_fifo_en", 32'(bus.fifo_en), ok ? 32'(4'b0001 << lane) : 32'd0);
    if (ok) push_exp(lane, data);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check_val("wr_err", 32'(bus.wr_err), 32'(!ok));
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input int wr_at, input int abort_at, input int co_lane);
    logic [LANES-1:0] exp_en;
    logic [LANES-1:0] exp_ov;
    bus.start = 1'b1;
    if (co_lane >= 0) begin
      bus.wr_valid = 1'b1;
      bus.wr_lane  = 2'(co_lane);
      host_d       = 8'hC3;
    end
    @(negedge clk);
    check_val("pre_busy", 32'(bus.busy), 32'd0);
    if (co_lane >= 0) begin
      check_val("co_ready", 32'(bus.wr_ready), 32'd1);
      check_val("co_fifo_en", 32'(bus.fifo_en), 32'(4'b0001 << co_lane));
      push_exp(co_lane, 8'hC3);
    end
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.wr_valid = 1'b0;
    for (int t = 0; t < LANES + DEPTH - 1; t++) begin
      if (t == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_val("abort_fifo_en", 32'(bus.fifo_en), 32'd0);
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        check_val("abort_out_valid", 32'(bus.out_valid), 32'd0);
        sb_q.delete();
        for (int i = 0; i < LANES; i++) exp_cnt[i] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (t == wr_at) begin
        bus.wr_valid = 1'b1;
        bus.wr_lane  = 2'd0;
      end
      @(negedge clk);
      for (int i = 0; i < LANES; i++) begin
        exp_en[i] = (t >= i) && (t - i < DEPTH);
        exp_ov[i] = exp_en[i] && (t - i >= DEPTH - exp_cnt[i]);
      end
      check_val($sformatf("busy_t%0d", t), 32'(bus.busy), 32'd1);
      check_val($sformatf("din_zero_t%0d", t), 32'(bus.fifo_din_zero), 32'd1);
      check_val($sformatf("fifo_en_t%0d", t), 32'(bus.fifo_en), 32'(exp_en));
      check_val($sformatf("out_valid_t%0d", t), 32'(bus.out_valid), 32'(exp_ov));
      check_val($sformatf("done_t%0d", t), 32'(bus.done), 32'd0);
      check_val($sformatf("wr_err_t%0d", t), 32'(bus.wr_err), 32'(wr_at >= 0 && t == wr_at + 1));
      if (t == wr_at) check_val("stream_wr_ready", 32'(bus.wr_ready), 32'd0);
      @(posedge clk); #1;
      bus.wr_valid = 1'b0;
    end
    @(negedge clk);
    check_val("end_busy", 32'(bus.busy), 32'd0);
    check_val("end_done", 32'(bus.done), 32'd1);
    check_val("end_din_zero", 32'(bus.fifo_din_zero), 32'd0);
    check_val("end_fifo_en", 32'(bus.fifo_en), 32'd0);
    for (int i = 0; i < LANES; i++) exp_cnt[i] = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("done_pulse_len", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.wr_valid  = 1'b0;
    bus.wr_lane   = '0;
    bus.start     = 1'b0;
    bus3.wr_valid = 1'b0;
    bus3.wr_lane  = '0;
    bus3.start    = 1'b0;
    host_d        = 8'h00;
    for (int i = 0; i < LANES; i++) exp_cnt[i] = 0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_fifo_en", 32'(bus.fifo_en), 32'd0);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_wr_err", 32'(bus.wr_err), 32'd0);
    check_val("rst_din_zero", 32'(bus.fifo_din_zero), 32'd0);
    @(posedge clk); #1;

    // Full load, overflow attempt on lane 0, then full drain.
    for (int l = 0; l < LANES; l++)
      for (int k = 0; k < DEPTH; k++) do_write(l, 8'(8'h10 * (l + 1) + k), 1'b1);
    do_write(0, 8'hEE, 1'b0);
    run_stream(-1, -1, -1);

    // Partial lane 1, plus a write attempt while streaming.
    do_write(1, 8'hA1, 1'b1);
    do_write(1, 8'hA2, 1'b1);
    run_stream(2, -1, -1);

    // Write to lane 2 accepted in the same cycle as start.
    run_stream(-1, -1, 2);

    // Reset mid-stream, then a stream with nothing loaded.
    do_write(3, 8'hD1, 1'b1);
    run_stream(-1, 2, -1);
    run_stream(-1, -1, -1);

    // Three-lane bank: lane index 3 is out of range.
    bus3.wr_valid = 1'b1;
    bus3.wr_lane  = 2'd3;
    @(negedge clk);
    check_val("l3_oor_ready", 32'(bus3.wr_ready), 32'd0);
    check_val("l3_oor_fifo_en", 32'(bus3.fifo_en), 32'd0);
    @(posedge clk); #1;
    bus3.wr_lane = 2'd2;
    @(negedge clk);
    check_val("l3_oor_err", 32'(bus3.wr_err), 32'd1);
    check_val("l3_ok_ready", 32'(bus3.wr_ready), 32'd1);
    check_val("l3_ok_fifo_en", 32'(bus3.fifo_en), 32'd4);
    @(posedge clk); #1;
    bus3.wr_valid = 1'b0;
    @(negedge clk);
    check_val("l3_ok_err", 32'(bus3.wr_err), 32'd0);

    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
